// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM state
// encoding, instruction width, NOP word and PC step.
// Optional feature macro used by the top: IF_FETCH_PERF_EN.
package if_fetch_unit_pkg;

    localparam int          INSTR_W     = 32;
    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0000;
    localparam int          PC_INC      = 4;

    // REQ  : driving a request at pc, waiting for grant
    // WAIT : request granted, waiting for the instruction word
    // DROP : a redirect overtook the outstanding request; swallow its response
    // HOLD : a valid instruction is presented to the IF/ID register
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
// Handshake: the master holds mem_req/mem_addr stable until a cycle with
// mem_req && mem_gnt (request accepted); exactly one response follows later
// as a single-cycle mem_rvalid pulse carrying mem_rdata. At most one request
// is outstanding, so the master never raises mem_req while awaiting rvalid.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import if_fetch_unit_pkg::*;

    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [INSTR_W-1:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register for the fetch unit: load wins over increment,
// otherwise hold. Also provides pc+4 (wrapping modulo 2^ADDR_W).
module if_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next pc: redirect target, sequential step, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + STEP;
        end
    end

    // PC register with synchronous reset to RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + STEP;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Owns the pc, fetches one word at a time over
// the request/grant/response bus, presents it to IF/ID while in HOLD, and
// emits NOP bubbles with fetch_stall elsewhere. Taken branches redirect pc
// and any in-flight response is discarded.
// Optional: define IF_FETCH_PERF_EN to add saturating stall/redirect counters.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = NOP_INSTR_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [ADDR_W-1:0]    branch_addr,
    if_fetch_unit_if.master      mem,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [INSTR_W-1:0]   instr_out,
    output logic                 fetch_stall,
    output fetch_state_e         dbg_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_redirect_cnt
`endif
);

    fetch_state_e         state_q;
    fetch_state_e         state_d;
    logic [INSTR_W-1:0]   ibuf_q;
    logic [INSTR_W-1:0]   ibuf_d;
    logic                 pc_load;
    logic                 pc_inc;
    logic                 req;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_plus4;

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pc_load),
        .load_addr_i (branch_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc),
        .pc_plus4_o  (pc_plus4)
    );

    // Fetch FSM next-state and pc control; branch_taken outranks freeze.
    always_comb begin
        state_d = state_q;
        ibuf_d  = ibuf_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        req     = 1'b0;
        case (state_q)
            ST_REQ: begin
                req = 1'b1;
                if (branch_taken) begin
                    pc_load = 1'b1;
                end
                if (mem.mem_gnt) begin
                    // A grant on the redirect cycle fetches a stale address.
                    state_d = branch_taken ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    if (branch_taken) begin
                        pc_load = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        ibuf_d  = mem.mem_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (branch_taken) begin
                    pc_load = 1'b1;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                end
                if (mem.mem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    state_d = ST_REQ;
                end else if (!freeze) begin
                    pc_inc  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // FSM state and instruction buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            ibuf_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            ibuf_q  <= ibuf_d;
        end
    end

    assign mem.mem_req  = req;
    assign mem.mem_addr = pc;
    assign pc_out       = pc_plus4;
    assign fetch_stall  = (state_q != ST_HOLD);
    assign instr_out    = (state_q == ST_HOLD) ? ibuf_q : NOP_INSTR;
    assign dbg_state    = state_q;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    // Saturating counters of bubble cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (fetch_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_taken && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a flag-based behavioural model of the fetch
// rules, plus a scoreboard of the first fetched instructions.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         freeze;
    logic         branch_taken;
    logic [31:0]  branch_addr;
    logic [31:0]  pc_out;
    logic [31:0]  instr_out;
    logic         fetch_stall;
    fetch_state_e dbg_state;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]  perf_stall_cnt;
    logic [31:0]  perf_redirect_cnt;
`endif

    if_fetch_unit_if #(.ADDR_W(32)) mem_bus ();

    // Clock
    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W    (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem          (mem_bus.master),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .fetch_stall  (fetch_stall),
        .dbg_state    (dbg_state)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pc plus three facts about the fetch in progress.
    bit          m_valid = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_have;     // an instruction is being presented
    bit          m_outst;    // a granted request awaits its response
    bit          m_disc;     // that response must be thrown away
    logic [31:0] m_stall_cnt;
    logic [31:0] m_redir_cnt;

    // Memory agent state.
    int          mem_cnt = 0;
    logic [31:0] mem_data;
    bit          dead_next = 1'b0;

    // Scoreboard of presented instructions (captured on first cycle shown).
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] got_pc_q[$];
    int          got_cyc_q[$];
    bit          record_on = 1'b0;
    bit          prev_stall = 1'b1;
    bit          seen_dead = 1'b0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs,
    // advance memory agent and model, return at the next falling edge.
    task automatic cycle(input bit r, input bit fr, input bit br, input logic [31:0] ba,
                         input bit g_en, input int lat);
        bit          grant;
        bit          g;
        bit          rv;
        logic [31:0] rd;
        rst          = r;
        freeze       = fr;
        branch_taken = br;
        branch_addr  = ba;
        rv = (mem_cnt == 1);
        rd = rv ? mem_data : $urandom;
        g  = g_en && (mem_cnt == 0);
        mem_bus.mem_rvalid = rv;
        mem_bus.mem_rdata  = rd;
        mem_bus.mem_gnt    = g;
        #1;
        if (m_valid) begin
            check_eq("mem_req",     {31'b0, mem_bus.mem_req}, {31'b0, (!m_have && !m_outst)});
            check_eq("mem_addr",    mem_bus.mem_addr, m_pc);
            check_eq("instr_out",   instr_out, m_have ? m_instr : NOP);
            check_eq("fetch_stall", {31'b0, fetch_stall}, {31'b0, !m_have});
            check_eq("pc_out",      pc_out, m_pc + 32'd4);
`ifdef IF_FETCH_PERF_EN
            check_eq("perf_stall",    perf_stall_cnt, m_stall_cnt);
            check_eq("perf_redirect", perf_redirect_cnt, m_redir_cnt);
`endif
        end
        if (!fetch_stall) begin
            if (record_on && prev_stall) begin
                got_q.push_back(instr_out);
                got_pc_q.push_back(pc_out);
                got_cyc_q.push_back(cyc);
            end
            if (instr_out == 32'h0000_DEAD) seen_dead = 1'b1;
        end
        prev_stall = fetch_stall;
        // memory agent: one response per accepted request, lat cycles later
        grant = mem_bus.mem_req && g;
        if (mem_cnt > 0) mem_cnt--;
        if (grant) begin
            mem_cnt   = (lat < 1) ? 1 : lat;
            mem_data  = dead_next ? 32'h0000_DEAD : mem_bus.mem_addr;
            dead_next = 1'b0;
        end
        // model
        if (r) begin
            m_valid = 1'b1;
            m_pc = RESET_PC; m_instr = NOP;
            m_have = 1'b0; m_outst = 1'b0; m_disc = 1'b0;
            m_stall_cnt = 32'd0; m_redir_cnt = 32'd0;
        end else begin
            if (!m_have && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (br && m_redir_cnt != 32'hFFFF_FFFF) m_redir_cnt++;
            if (m_have) begin
                if (br) begin
                    m_pc = ba; m_have = 1'b0;
                end else if (!fr) begin
                    m_pc = m_pc + 32'd4; m_have = 1'b0;
                end
            end else if (!m_outst) begin
                if (g) begin
                    m_outst = 1'b1; m_disc = br;
                end
                if (br) m_pc = ba;
            end else begin
                if (rv) begin
                    m_outst = 1'b0;
                    if (!m_disc && !br) begin
                        m_have = 1'b1; m_instr = rd;
                    end
                    m_disc = 1'b0;
                end else if (br) begin
                    m_disc = 1'b1;
                end
                if (br) m_pc = ba;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Idle cycles (no grant) until the DUT requests again, bounded.
    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!mem_bus.mem_req && n < budget) begin
            cycle(0, 0, 0, 32'd0, 0, 1);
            n++;
        end
        check_eq(tag, {31'b0, mem_bus.mem_req}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
        @(negedge clk);
        cycle(1, 0, 0, 32'd0, 0, 1);
        cycle(1, 0, 0, 32'd0, 0, 1);

        // reset state
        check_eq("rst_req",   {31'b0, mem_bus.mem_req}, 32'd1);
        check_eq("rst_addr",  mem_bus.mem_addr, RESET_PC);
        check_eq("rst_instr", instr_out, NOP);
        check_eq("rst_stall", {31'b0, fetch_stall}, 32'd1);
        check_eq("rst_pcout", pc_out, RESET_PC + 32'd4);

        // back-to-back fetches with a one-cycle memory
        cyc = 0;
        record_on = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        repeat (8) cycle(0, 0, 0, 32'd0, 1, 1);
        // freeze while holding pc=0x8
        for (int i = 0; i < 5; i++) begin
            check_eq("frz_instr", instr_out, 32'h8);
            check_eq("frz_pcout", pc_out, 32'hC);
            check_eq("frz_req",   {31'b0, mem_bus.mem_req}, 32'd0);
            cycle(0, 1, 0, 32'd0, 1, 1);
        end
        record_on = 1'b0;
        check_eq("sb_count", got_q.size(), 32'd3);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq("sb_instr", got_q[i], exp_q[i]);
            check_eq("sb_pcout", got_pc_q[i], exp_q[i] + 32'd4);
            check_eq("sb_cycle", got_cyc_q[i], 2 + 3 * i);
        end
        cycle(0, 0, 0, 32'd0, 1, 1);
        check_eq("resume_addr", mem_bus.mem_addr, 32'hC);

        // redirect while waiting; the late 0xDEAD response must vanish
        dead_next = 1'b1;
        cycle(0, 0, 0, 32'd0, 1, 3);
        cycle(0, 0, 1, 32'h100, 0, 1);
        wait_req("drop_req", 10);
        check_eq("drop_addr", mem_bus.mem_addr, 32'h100);

        // redirect coinciding with the response
        cycle(0, 0, 0, 32'd0, 1, 1);
        cycle(0, 0, 1, 32'h200, 0, 1);
        check_eq("coin_req",   {31'b0, mem_bus.mem_req}, 32'd1);
        check_eq("coin_addr",  mem_bus.mem_addr, 32'h200);
        check_eq("coin_stall", {31'b0, fetch_stall}, 32'd1);

        // grant withheld for four cycles
        for (int i = 0; i < 4; i++) begin
            check_eq("gdly_req",   {31'b0, mem_bus.mem_req}, 32'd1);
            check_eq("gdly_addr",  mem_bus.mem_addr, 32'h200);
            check_eq("gdly_stall", {31'b0, fetch_stall}, 32'd1);
            cycle(0, 0, 0, 32'd0, 0, 1);
        end

        // reset while waiting; stray response afterwards
        cycle(0, 0, 0, 32'd0, 1, 2);
        cycle(1, 0, 0, 32'd0, 0, 1);
        check_eq("mrst_addr",  mem_bus.mem_addr, RESET_PC);
        check_eq("mrst_req",   {31'b0, mem_bus.mem_req}, 32'd1);
`ifdef IF_FETCH_PERF_EN
        check_eq("mrst_pstall", perf_stall_cnt, 32'd0);
        check_eq("mrst_predir", perf_redirect_cnt, 32'd0);
`endif
        cycle(0, 0, 0, 32'd0, 1, 1);
        check_eq("stray_stall", {31'b0, fetch_stall}, 32'd1);
        check_eq("stray_addr",  mem_bus.mem_addr, RESET_PC);
        cycle(0, 0, 0, 32'd0, 1, 1);
        cycle(0, 0, 0, 32'd0, 1, 1);
        check_eq("refetch_stall", {31'b0, fetch_stall}, 32'd0);
        check_eq("refetch_pcout", pc_out, RESET_PC + 32'd4);

        // random traffic, including redirects to the top of the address space
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          fr;
            bit          br;
            bit          g_en;
            logic [31:0] ba;
            r    = ($urandom_range(0, 199) == 0);
            fr   = ($urandom_range(0, 99) < 25);
            br   = ($urandom_range(0, 99) < 8);
            g_en = ($urandom_range(0, 99) < 60);
            ba   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFFC;
            cycle(r, fr, br, ba, g_en, $urandom_range(1, 4));
        end

        check_eq("no_dead", {31'b0, seen_dead}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
